// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver.
// Sync, glitch filter, frame FSM and FWFT byte FIFO.
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 4096,
  parameter int FIFO_BITS  = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam logic [7:0] FLT_LAST =
    8'(FILTER_LEN - 1);
  localparam logic [15:0] TMO_LAST =
    16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic [1:0]          clk_s_q;
  logic [1:0]          dat_s_q;
  logic [FILTER_LEN:0] dly_q;
  logic [7:0]          flt_cnt_q;
  logic                flt_q;
  logic                flt_prev_q;
  logic                fall_q;
  logic                bit_w;

  state_e              state_q;
  logic [2:0]          bcnt_q;
  logic                acc_q;
  logic [7:0]          sh_q;
  logic [15:0]         tmo_q;
  logic                perr_q;
  logic                ferr_q;
  logic                terr_q;
  logic                push_w;

  logic [7:0]          mem_q [DEPTH];
  logic [FIFO_BITS:0]  wptr_q;
  logic [FIFO_BITS:0]  rptr_q;
  logic [FIFO_BITS:0]  wptr_d;
  logic [FIFO_BITS:0]  rptr_d;
  logic                ovf_q;
  logic                pop_w;
  logic                wr_w;

  // Data is delayed so it lines up with the filtered clock.
  assign bit_w = dly_q[FILTER_LEN];

  // Two-stage synchronisers and data delay line.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s_q <= 2'b11;
      dat_s_q <= 2'b11;
      dly_q   <= '1;
    end else begin
      clk_s_q <= {clk_s_q[0], ps2_clk};
      dat_s_q <= {dat_s_q[0], ps2_data};
      dly_q   <= {dly_q[FILTER_LEN-1:0],
                  dat_s_q[1]};
    end
  end

  // Clock filter and registered falling-edge strobe.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      flt_cnt_q  <= '0;
      flt_q      <= 1'b1;
      flt_prev_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      flt_prev_q <= flt_q;
      fall_q     <= flt_prev_q & ~flt_q;
      if (clk_s_q[1] == flt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        flt_q     <= clk_s_q[1];
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 8'd1;
      end
    end
  end

  // Good byte leaves the FSM on the stop-bit fall.
  assign push_w = fall_q && (state_q == STOP) &&
                  bit_w && acc_q;

  // Frame FSM with timeout watchdog.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      acc_q   <= 1'b0;
      sh_q    <= '0;
      tmo_q   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      terr_q <= 1'b0;
      if (fall_q) begin
        tmo_q <= '0;
        unique case (state_q)
          IDLE: begin
            if (!bit_w) begin
              state_q <= DATA;
              bcnt_q  <= '0;
              acc_q   <= 1'b0;
            end
          end
          DATA: begin
            sh_q   <= {bit_w, sh_q[7:1]};
            acc_q  <= acc_q ^ bit_w;
            bcnt_q <= bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            acc_q   <= acc_q ^ bit_w;
            state_q <= STOP;
          end
          STOP: begin
            ferr_q  <= ~bit_w;
            perr_q  <= bit_w & ~acc_q;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q == IDLE) begin
        tmo_q <= '0;
      end else if (tmo_q == TMO_LAST) begin
        terr_q  <= 1'b1;
        state_q <= IDLE;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + 16'd1;
      end
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  =
    (wptr_q[FIFO_BITS] != rptr_q[FIFO_BITS]) &&
    (wptr_q[FIFO_BITS-1:0] ==
     rptr_q[FIFO_BITS-1:0]);
  assign pop_w  = rd & ~empty;
  // A pop in the same cycle frees the slot.
  assign wr_w   = push_w & (~full | pop_w);
  assign wptr_d = wptr_q + {{FIFO_BITS{1'b0}}, wr_w};
  assign rptr_d = rptr_q + {{FIFO_BITS{1'b0}}, pop_w};

  // FIFO pointers and overflow pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= push_w & full & ~pop_w;
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk_sys) begin
    if (wr_w) begin
      mem_q[wptr_q[FIFO_BITS-1:0]] <= sh_q;
    end
  end

  assign dout        = mem_q[rptr_q[FIFO_BITS-1:0]];
  assign busy        = (state_q != IDLE);
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;
  assign overflow    = ovf_q;

endmodule
